// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared state encoding and modulus table for the variable-modulus counters
package cnt_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] MOD_MAX_00 = 4'd5;
  localparam logic [CNT_W-1:0] MOD_MAX_01 = 4'd7;
  localparam logic [CNT_W-1:0] MOD_MAX_10 = 4'd9;
  localparam logic [CNT_W-1:0] MOD_MAX_11 = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_e;

  function automatic logic [CNT_W-1:0] mod_max(input logic [1:0] sw);
    case (sw)
      2'b00:   mod_max = MOD_MAX_00;
      2'b01:   mod_max = MOD_MAX_01;
      2'b10:   mod_max = MOD_MAX_10;
      default: mod_max = MOD_MAX_11;
    endcase
  endfunction

endpackage

// File: rtl/var_mod_decode.sv
// rtl/var_mod_decode.sv - modulus select to terminal (reload) value decode
module var_mod_decode #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] MAX_00 = 4'd5,
  parameter logic [WIDTH-1:0] MAX_01 = 4'd7,
  parameter logic [WIDTH-1:0] MAX_10 = 4'd9,
  parameter logic [WIDTH-1:0] MAX_11 = 4'd14
) (
  input  logic [1:0]       sw_i,
  output logic [WIDTH-1:0] max_o
);

  always_comb begin
    case (sw_i)
      2'b00:   max_o = MAX_00;
      2'b01:   max_o = MAX_01;
      2'b10:   max_o = MAX_10;
      default: max_o = MAX_11;
    endcase
  end

endmodule

// File: rtl/var_down_counter.sv
// rtl/var_down_counter.sv - variable-modulus down counter with free-run and one-shot modes
module var_down_counter
  import cnt_pkg::*;
#(
  parameter int               WIDTH  = CNT_W,
  parameter logic [WIDTH-1:0] MAX_00 = MOD_MAX_00,
  parameter logic [WIDTH-1:0] MAX_01 = MOD_MAX_01,
  parameter logic [WIDTH-1:0] MAX_10 = MOD_MAX_10,
  parameter logic [WIDTH-1:0] MAX_11 = MOD_MAX_11
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic             En,
  input  logic [1:0]       SW,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  output logic [WIDTH-1:0] Q,
  output logic             Borrow,
  output logic             Done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] max;
  logic             step;

  var_mod_decode #(
    .WIDTH  (WIDTH),
    .MAX_00 (MAX_00),
    .MAX_01 (MAX_01),
    .MAX_10 (MAX_10),
    .MAX_11 (MAX_11)
  ) u_decode (
    .sw_i  (SW),
    .max_o (max)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    borrow_d = 1'b0;
    step     = 1'b0;
    if (Load) begin
      q_d     = (D > max) ? max : D;
      state_d = Start ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (Start) state_d = RUN;
        RUN:  step = En;
        DONE: begin
          if (Start) begin
            state_d = RUN;
            step    = En;
          end
        end
        default: state_d = IDLE;
      endcase
      // Order matters: an out-of-range count (SW changed mid-run) is clamped before any wrap.
      if (step) begin
        if (q_q > max) begin
          q_d = max;
        end else if (q_q == '0) begin
          if (!Mode) begin
            q_d      = max;
            borrow_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (q_q == ONE && Mode) begin
          q_d     = '0;
          state_d = DONE;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge CP) begin
    if (CLR) begin
      state_q  <= IDLE;
      q_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      borrow_q <= borrow_d;
    end
  end

  assign Q      = q_q;
  assign Borrow = borrow_q;
  assign Done   = (state_q == DONE);

endmodule

// File: tb/tb_var_down_counter.sv
// tb/tb_var_down_counter.sv - directed self-checking bench for var_down_counter
module tb_var_down_counter;

  logic       CP = 1'b0;
  logic       CLR, En, Mode, Load, Start;
  logic [1:0] SW;
  logic [3:0] D, Q;
  logic       Borrow, Done;

  logic       hi_mode, hi_load, hi_start;
  logic [1:0] hi_sw;
  logic [3:0] hi_d, hi_q;
  logic       hi_borrow, hi_done;

  int checks = 0;
  int errors = 0;

  var_down_counter dut (
    .CP(CP), .CLR(CLR), .En(En), .SW(SW), .Mode(Mode), .Load(Load),
    .D(D), .Start(Start), .Q(Q), .Borrow(Borrow), .Done(Done)
  );

  var_down_counter dut_hi (
    .CP(CP), .CLR(CLR), .En(Borrow), .SW(hi_sw), .Mode(hi_mode), .Load(hi_load),
    .D(hi_d), .Start(hi_start), .Q(hi_q), .Borrow(hi_borrow), .Done(hi_done)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  int fr_q[6]   = '{2, 1, 0, 9, 8, 7};
  int fr_b[6]   = '{0, 0, 0, 1, 0, 0};
  int hi_exp[9] = '{2, 2, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    CLR = 1'b1; En = 1'b1; Start = 1'b1; Load = 1'b0; Mode = 1'b0; SW = 2'b10; D = 4'd0;
    hi_mode = 1'b0; hi_load = 1'b0; hi_start = 1'b0; hi_sw = 2'b10; hi_d = 4'd0;
    tick();
    check("rst_q", Q, 0);
    check("rst_done", Done, 0);
    check("rst_borrow", Borrow, 0);
    CLR = 1'b0; Start = 1'b0;
    tick();
    check("rst_idle_hold", Q, 0);

    // free-run mod 10 from 3
    Load = 1'b1; D = 4'd3; En = 1'b0;
    tick();
    check("fr_load", Q, 3);
    Load = 1'b0; Start = 1'b1; En = 1'b1;
    tick();
    check("fr_start", Q, 3);
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("fr_q%0d", i), Q, fr_q[i]);
      check($sformatf("fr_b%0d", i), Borrow, fr_b[i]);
    end
    tick();
    check("hold_pre", Q, 6);
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_q%0d", i), Q, 6);
      check($sformatf("hold_b%0d", i), Borrow, 0);
    end

    // one-shot mod 6 from 2
    SW = 2'b00; Mode = 1'b1; Load = 1'b1; D = 4'd2;
    tick();
    check("os_load", Q, 2);
    Load = 1'b0; Start = 1'b1; En = 1'b1;
    tick();
    check("os_start", Q, 2);
    Start = 1'b0;
    tick();
    check("os_q1", Q, 1);
    check("os_done_q1", Done, 0);
    tick();
    check("os_q0", Q, 0);
    check("os_done", Done, 1);
    tick();
    check("os_hold_q", Q, 0);
    check("os_hold_done", Done, 1);
    Mode = 1'b0;
    tick();
    check("os_m0_done", Done, 1);
    check("os_m0_q", Q, 0);
    Start = 1'b1;
    tick();
    check("os_restart_q", Q, 5);
    check("os_restart_b", Borrow, 1);
    check("os_restart_done", Done, 0);
    Start = 1'b0;
    tick();
    check("os_run_q", Q, 4);
    check("os_run_b", Borrow, 0);

    // clamp on load and on SW change mid-run
    En = 1'b0; Load = 1'b1; D = 4'd12;
    tick();
    check("clamp_load", Q, 5);
    SW = 2'b11;
    tick();
    check("load_12", Q, 12);
    Load = 1'b0; Start = 1'b1; En = 1'b1;
    tick();
    check("sw_run", Q, 12);
    Start = 1'b0; SW = 2'b01;
    tick();
    check("sw_clamp_q", Q, 7);
    check("sw_clamp_b", Borrow, 0);
    tick();
    check("sw_after", Q, 6);

    // Load + Start + En on one edge
    Load = 1'b1; Start = 1'b1; D = 4'd4;
    tick();
    check("prio_q", Q, 4);
    Load = 1'b0; Start = 1'b0;
    tick();
    check("prio_next", Q, 3);

    // one-shot from a loaded zero, then Load out of DONE
    Mode = 1'b1; Load = 1'b1; Start = 1'b1; D = 4'd0;
    tick();
    check("zero_q", Q, 0);
    check("zero_done0", Done, 0);
    Load = 1'b0; Start = 1'b0;
    tick();
    check("zero_done1", Done, 1);
    Load = 1'b1; D = 4'd3;
    tick();
    check("done_load_q", Q, 3);
    check("done_load_done", Done, 0);
    Load = 1'b0;
    tick();
    check("idle_hold", Q, 3);

    // cascade: lower mod 6 from 1, upper mod 10 from 2
    CLR = 1'b1;
    tick();
    CLR = 1'b0; Mode = 1'b0; SW = 2'b00; En = 1'b0;
    Load = 1'b1; Start = 1'b1; D = 4'd1;
    hi_load = 1'b1; hi_start = 1'b1; hi_d = 4'd2;
    tick();
    check("cas_lo_init", Q, 1);
    check("cas_hi_init", hi_q, 2);
    Load = 1'b0; Start = 1'b0; hi_load = 1'b0; hi_start = 1'b0; En = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("cas_hi%0d", i), hi_q, hi_exp[i]);
    end
    check("cas_lo_end", Q, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
